// File: rtl/and16_serial_pkg.sv
// ============================================================================
// and16_serial_pkg : shared widths, state encoding and word-completion helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package and16_serial_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  // The final beat's bit never sits in the collect register, so it is
  // merged into the top bit here.
  function automatic logic [WORD_W-1:0] complete_word(
    input logic [WORD_W-1:0] collect,
    input logic              last_bit
  );
    logic [WORD_W-1:0] w;
    w             = collect;
    w[WORD_W-1]   = last_bit;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/and16_serial_if.sv
// ============================================================================
// and16_serial_if : bit-pair input handshake and word output handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

interface and16_serial_if;
  import and16_serial_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              a_bit;
  logic              b_bit;
  logic [WORD_W-1:0] out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_valid, a_bit, b_bit, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in_valid, a_bit, b_bit, out_ready,
    output in_ready, out, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/and16_serial_sipo16.sv
// ============================================================================
// sipo16 : 16-bit collect register, one indexed bit written per enabled cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module sipo16
  import and16_serial_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              clr_i,
  input  wire logic              wr_en_i,
  input  wire logic [CNT_W-1:0]  idx_i,
  input  wire logic              bit_i,
  output logic      [WORD_W-1:0] word_o
);

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_bit
    assign word_d[gi] = (wr_en_i && (idx_i == CNT_W'(gi))) ? bit_i : word_q[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (clr_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

`default_nettype wire

// File: rtl/and16_serial.sv
// ============================================================================
// and16_serial : serial LSB-first bitwise AND of two operands into a word
// Revision: 1.0
// ============================================================================
`default_nettype none

module and16_serial
  import and16_serial_pkg::*;
#(
  parameter int WIDTH = WORD_W
)(
  input  wire logic     clk,
  input  wire logic     rst_n,
  and16_serial_if.slave bus
);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [WIDTH-1:0]  out_q;
  logic              out_valid_q;

  logic              w_beat;
  logic              w_bit;
  logic              w_last;
  logic [WIDTH-1:0]  w_collect;
  logic [WIDTH-1:0]  w_word_done;

  assign w_beat      = bus.in_valid && (state_q == ST_COLLECT);
  assign w_bit       = bus.a_bit & bus.b_bit;
  assign w_last      = w_beat && (cnt_q == CNT_W'(WORD_W - 1));
  assign cnt_d       = cnt_q + 1'b1;
  assign w_word_done = complete_word(w_collect, w_bit);

  // Cleared on completion so a fresh word never inherits stale bits.
  sipo16 u_sipo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (w_last),
    .wr_en_i (w_beat),
    .idx_i   (cnt_q),
    .bit_i   (w_bit),
    .word_o  (w_collect)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (w_beat) begin
            cnt_q <= cnt_d;
            if (w_last) begin
              out_q       <= w_word_done;
              out_valid_q <= 1'b1;
              state_q     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_COLLECT;
          end
        end
        default: begin
          state_q <= ST_COLLECT;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_COLLECT);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: doc/and16_serial.md
AND16_SERIAL -- requirements
Module: and16_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16: word width; fixed at 16 in this revision.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: a_bit/b_bit carry a valid bit pair this cycle.
REQ-005 SHALL have port in_ready, output, 1: block accepts a bit pair this cycle.
REQ-006 SHALL have port a_bit, input, 1: serial operand A bit, LSB first.
REQ-007 SHALL have port b_bit, input, 1: serial operand B bit, LSB first.
REQ-008 SHALL have port out, output, 16: last completed word, out[i] = a[i] AND b[i].
REQ-009 SHALL have port out_valid, output, 1: out holds a completed, unconsumed word.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the word this cycle.

Function
REQ-011 SHALL implement a two-state FSM: COLLECT and HOLD.
REQ-012 SHALL define a beat as in_valid && in_ready on a rising clk edge.
REQ-013 SHALL drive in_ready = 1 in COLLECT and in_ready = 0 in HOLD, with in_ready purely decoded from state.
REQ-014 SHALL, on a beat, write (a_bit AND b_bit) into internal collect-register bit index cnt, then increment the 4-bit counter cnt.
REQ-015 SHALL leave cnt and the collect register unchanged in cycles with in_valid = 0; gaps of any length are allowed.
REQ-016 SHALL, on the beat with cnt == 15, load out with the completed word, set out_valid = 1, wrap cnt to 0, and enter HOLD; out_valid is visible the cycle after the 16th beat.
REQ-017 SHALL keep out and out_valid stable in HOLD until out_valid && out_ready.
REQ-018 SHALL, on out_valid && out_ready, clear out_valid and return to COLLECT; out retains its value.
REQ-019 SHALL ignore a_bit/b_bit/in_valid while in HOLD, including the handshake cycle; no pass-through, so one bubble cycle separates words.
REQ-020 SHALL change out only at word completion; partial words are never visible on out.
REQ-021 SHALL ignore out_ready while out_valid = 0.

Reset
REQ-022 SHALL, on rst_n low and asynchronously, force state = COLLECT, cnt = 0, the collect register = 0, out = 16'h0000, out_valid = 0; in_ready = 1 during reset.
REQ-023 SHALL discard any partial word on reset mid-collection; the first beat after rst_n rises is bit 0.
REQ-024 SHALL discard a pending HOLD word on reset.

Structure
REQ-025 SHALL place WIDTH = 16, the counter width = 4, and the COLLECT/HOLD state encoding in a shared package.
REQ-026 SHALL implement the bit AND combinationally and use one sub-module, sipo16, a 16-bit serial-in/indexed-write collect register with clear.
REQ-027 SHALL contain no latches and no combinational path from inputs to in_ready or out_valid.

Verification
REQ-028 SHALL cover reset: during and after rst_n low -> out = 0x0000, out_valid = 0, in_ready = 1.
REQ-029 SHALL cover a contiguous stream a = 0x00FF, b = 0xFFFF over 16 beats -> out = 0x00FF; out_valid rises exactly 1 cycle after the 16th beat.
REQ-030 SHALL cover a gapped stream a = 0xA5A5, b = 0x0FF0 with in_valid low every other cycle -> out = 0x05A0 after exactly 16 beats, with no early out_valid.
REQ-031 SHALL cover backpressure: out_ready low for 5 cycles after completion, with in_valid high and random bits -> out_valid held, out unchanged, in_ready = 0; after handshake, the next word assembles correctly from bit 0.
REQ-032 SHALL cover reset after 7 beats of a = 0xFFFF, b = 0xFFFF, then 16 beats of a = 0x1234, b = 0xFFFF -> out = 0x1234 with no leftover bits.
REQ-033 SHALL cover back-to-back words with out_ready tied 1: 0xFFFF & 0x1234, then 0xF0F0 & 0xFFFF -> out = 0x1234, then 0xF0F0, with exactly one in_ready-low bubble between words.
